ysyx_2022040010_icache_ctrl: RTL and testbench

Miss/refill sequencer for the 2-way, 64-set instruction cache with 8-byte lines. Watches the tag array's miss/hit/lru outputs and fetches the missing line over a single-beat memory read port. It then pulses refresh to the tag array and a write to the chosen data way. It also carries uncached fetches straight to memory, and holds the fetch stage stalled until each access resolves.

---
 rtl/ysyx_2022040010_icache_ctrl.sv | 152 +++++++++++++++
 tb/tb_ysyx_2022040010_icache_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_icache_ctrl.sv
// Miss/refill sequencer for the 2-way, 64-set icache: single-beat line refill
// over the memory read port, plus pass-through uncached fetches.
module ysyx_2022040010_icache_ctrl #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_e,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              cache,
  input  logic              flush,
  input  logic              miss,
  input  logic [1:0]        hit,
  input  logic              lru,
  output logic              refresh,
  output logic              data_we,
  output logic              data_way,
  output logic [LINE_W-1:0] data_wdata,
  output logic              uc_valid,
  output logic [LINE_W-1:0] uc_data,
  output logic              stallreq,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFill,
    StUcResp
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                way_q, way_d;
  logic                uncached_q, uncached_d;
  logic                drop_q, drop_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                line_changed;

  // Refresh indexes by the live fetch address, so a line change kills the refill.
  assign line_changed = sram_addr[ADDR_W-1:3] != addr_q[ADDR_W-1:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      way_q      <= 1'b0;
      uncached_q <= 1'b0;
      drop_q     <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      way_q      <= way_d;
      uncached_q <= uncached_d;
      drop_q     <= drop_d;
      line_q     <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    way_d      = way_q;
    uncached_d = uncached_q;
    drop_d     = drop_q;
    line_d     = line_q;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (sram_e && !flush) begin
          if (!cache) begin
            addr_d     = sram_addr;
            uncached_d = 1'b1;
            state_d    = StReq;
          end else if (miss) begin
            addr_d     = sram_addr;
            way_d      = lru;
            uncached_d = 1'b0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (flush || line_changed) drop_d = 1'b1;
        if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          line_d = mem_rdata;
          if (drop_q || flush || line_changed) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = uncached_q ? StUcResp : StFill;
          end
        end else if (flush || line_changed) begin
          drop_d = 1'b1;
        end
      end
      StFill, StUcResp: begin
        drop_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    refresh    = 1'b0;
    data_we    = 1'b0;
    data_way   = 1'b0;
    data_wdata = '0;
    uc_valid   = 1'b0;
    uc_data    = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    stallreq   = 1'b0;
    unique case (state_q)
      StIdle: stallreq = sram_e && !flush && (miss || !cache);
      StReq: begin
        stallreq = 1'b1;
        mem_req  = 1'b1;
        mem_addr = uncached_q ? addr_q : {addr_q[ADDR_W-1:3], 3'b000};
      end
      StWait: stallreq = 1'b1;
      StFill: begin
        stallreq   = 1'b1;
        refresh    = 1'b1;
        data_we    = 1'b1;
        data_way   = way_q;
        data_wdata = line_q;
      end
      StUcResp: begin
        uc_valid = 1'b1;
        uc_data  = line_q;
      end
      default: stallreq = 1'b0;
    endcase
  end

  // The tag array must report a clean one-hot-or-zero hit whenever it claims no miss.
  hit_onehot_a : assert property (@(posedge clk) disable iff (rst)
    (sram_e && !miss) |-> (!$isunknown(hit) && $onehot0(hit)));

endmodule

// File: tb/tb_ysyx_2022040010_icache_ctrl.sv
// Directed bench for the icache miss/refill sequencer.
module tb_ysyx_2022040010_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_e;
  logic [63:0] sram_addr;
  logic        cache;
  logic        flush;
  logic        miss;
  logic [1:0]  hit;
  logic        lru;
  logic        refresh;
  logic        data_we;
  logic        data_way;
  logic [63:0] data_wdata;
  logic        uc_valid;
  logic [63:0] uc_data;
  logic        stallreq;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  ysyx_2022040010_icache_ctrl #(.ADDR_W(64), .LINE_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_e     (sram_e),
    .sram_addr  (sram_addr),
    .cache      (cache),
    .flush      (flush),
    .miss       (miss),
    .hit        (hit),
    .lru        (lru),
    .refresh    (refresh),
    .data_we    (data_we),
    .data_way   (data_way),
    .data_wdata (data_wdata),
    .uc_valid   (uc_valid),
    .uc_data    (uc_data),
    .stallreq   (stallreq),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_outputs(input string tag);
    chk({tag, "_refresh"}, {63'd0, refresh}, 64'd0);
    chk({tag, "_data_we"}, {63'd0, data_we}, 64'd0);
    chk({tag, "_uc_valid"}, {63'd0, uc_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; sram_e = 1'b0; sram_addr = '0; cache = 1'b1; flush = 1'b0;
    miss = 1'b0; hit = 2'b00; lru = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
    step(); step();
    settle();
    quiet_outputs("reset");
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_stall", {63'd0, stallreq}, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_wdata", data_wdata, 64'd0);
    rst = 1'b0;
    step();

    // Cold miss, immediate grant, data three cycles after grant.
    sram_e = 1'b1; sram_addr = 64'h8000_0010; miss = 1'b1; lru = 1'b0;
    settle();
    chk("t1_idle_stall", {63'd0, stallreq}, 64'd1);
    chk("t1_idle_no_req", {63'd0, mem_req}, 64'd0);
    step();
    mem_gnt = 1'b1;
    settle();
    chk("t1_req", {63'd0, mem_req}, 64'd1);
    chk("t1_mem_addr", mem_addr, 64'h8000_0010);
    chk("t1_req_stall", {63'd0, stallreq}, 64'd1);
    step();
    mem_gnt = 1'b0;
    settle();
    chk("t1_req_dropped", {63'd0, mem_req}, 64'd0);
    chk("t1_wait_stall", {63'd0, stallreq}, 64'd1);
    step();
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0013;
    settle();
    chk("t1_wait_no_refresh", {63'd0, refresh}, 64'd0);
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    settle();
    chk("t1_fill_refresh", {63'd0, refresh}, 64'd1);
    chk("t1_fill_we", {63'd0, data_we}, 64'd1);
    chk("t1_fill_way", {63'd0, data_way}, 64'd0);
    chk("t1_fill_data", data_wdata, 64'hDEAD_BEEF_0000_0013);
    chk("t1_fill_stall", {63'd0, stallreq}, 64'd1);
    step();
    miss = 1'b0; hit = 2'b01;
    settle();
    quiet_outputs("t1_after");
    chk("t1_hit_no_stall", {63'd0, stallreq}, 64'd0);
    step();

    // Miss into way 1 with a grant delayed four cycles; unaligned fetch address.
    sram_addr = 64'h8000_010C; miss = 1'b1; hit = 2'b00; lru = 1'b1;
    step();
    lru = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_req_held", {63'd0, mem_req}, 64'd1);
      chk("t2_addr_held", mem_addr, 64'h8000_0108);
      step();
    end
    mem_gnt = 1'b1;
    settle();
    chk("t2_req_at_gnt", {63'd0, mem_req}, 64'd1);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    mem_rvalid = 1'b0;
    settle();
    chk("t2_fill_way", {63'd0, data_way}, 64'd1);
    chk("t2_fill_data", data_wdata, 64'h0123_4567_89AB_CDEF);
    step();
    miss = 1'b0; hit = 2'b10;
    settle();
    quiet_outputs("t2_after");
    step();

    // Uncached fetch: full address goes to memory, no refresh.
    cache = 1'b0; sram_addr = 64'h1000_0004; hit = 2'b00;
    settle();
    chk("t3_idle_stall", {63'd0, stallreq}, 64'd1);
    step();
    mem_gnt = 1'b1;
    settle();
    chk("t3_mem_addr", mem_addr, 64'h1000_0004);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h73;
    step();
    mem_rvalid = 1'b0; sram_e = 1'b0;
    settle();
    chk("t3_uc_valid", {63'd0, uc_valid}, 64'd1);
    chk("t3_uc_data", uc_data, 64'h73);
    chk("t3_uc_stall", {63'd0, stallreq}, 64'd0);
    chk("t3_no_refresh", {63'd0, refresh}, 64'd0);
    step();
    settle();
    chk("t3_uc_one_cycle", {63'd0, uc_valid}, 64'd0);
    // Stray rvalid in IDLE is ignored.
    mem_rvalid = 1'b1; mem_rdata = 64'h55;
    step();
    mem_rvalid = 1'b0;
    settle();
    quiet_outputs("t3_stray_rvalid");
    chk("t3_stray_no_req", {63'd0, mem_req}, 64'd0);

    // Flush during WAIT drops the refill, then the next miss is serviced.
    cache = 1'b1; sram_e = 1'b1; sram_addr = 64'h8000_0020; miss = 1'b1; lru = 1'b0;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    mem_rvalid = 1'b0;
    settle();
    quiet_outputs("t4_dropped");
    chk("t4_back_idle", {63'd0, mem_req}, 64'd0);
    step();
    settle();
    chk("t4_retry_req", {63'd0, mem_req}, 64'd1);
    chk("t4_retry_addr", mem_addr, 64'h8000_0020);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hC0DE_C0DE_1111_2222;
    step();
    mem_rvalid = 1'b0;
    settle();
    chk("t4_fill_refresh", {63'd0, refresh}, 64'd1);
    chk("t4_fill_data", data_wdata, 64'hC0DE_C0DE_1111_2222);
    step();
    miss = 1'b0; hit = 2'b01;
    step();

    // Fetch address leaves the line during WAIT: fill dropped.
    sram_addr = 64'h8000_0010; miss = 1'b1; hit = 2'b00;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; sram_addr = 64'h8000_0040;
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    mem_rvalid = 1'b0; sram_e = 1'b0;
    settle();
    quiet_outputs("t5_dropped");
    chk("t5_idle_stall", {63'd0, stallreq}, 64'd0);
    step();
    settle();
    chk("t5_no_refill", {63'd0, refresh}, 64'd0);

    // Reset while in REQ.
    sram_e = 1'b1; sram_addr = 64'h8000_0080; miss = 1'b1;
    step();
    settle();
    chk("t6_in_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1; sram_e = 1'b0;
    step();
    settle();
    chk("t6_rst_req", {63'd0, mem_req}, 64'd0);
    chk("t6_rst_addr", mem_addr, 64'd0);
    chk("t6_rst_stall", {63'd0, stallreq}, 64'd0);
    quiet_outputs("t6_rst");
    rst = 1'b0;
    step();
    settle();
    chk("t6_idle_after", {63'd0, mem_req}, 64'd0);
    chk("t6_idle_stall", {63'd0, stallreq}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
